// File: rtl/segment_pkg.sv
// Shared constants and glyph lookup for the segment scanner family.
// Pure definitions: no latency, no flow control.
package segment_pkg;

  localparam int         PWM_PHASES = 16;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  // Active-low common-anode patterns, bit7 = dp (off), bits6:0 = g..a
  localparam logic [7:0] SEG_GLYPH [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    return SEG_GLYPH[hex];
  endfunction

endpackage

// File: rtl/segment_scan_timer.sv
// Prescaler, PWM phase and digit counters; strobes are combinational from the registered counts.
// Free-running, no backpressure; a frame is NUM_DIGITS slots of PWM_PHASES ticks.
module segment_scan_timer
  import segment_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int TICK_DIV   = 2048,
  localparam int DIGIT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  output logic               tick,
  output logic               slot_start,
  output logic               frame_boundary,
  output logic [DIGIT_W-1:0] digit,
  output logic [3:0]         phase
);

  localparam int PRESC_W = $clog2(TICK_DIV);

  logic [PRESC_W-1:0] presc;

  assign tick           = (presc == PRESC_W'(TICK_DIV - 1));
  assign slot_start     = tick && (phase == 4'(PWM_PHASES - 1));
  assign frame_boundary = slot_start && (digit == DIGIT_W'(NUM_DIGITS - 1));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      phase <= '0;
      digit <= '0;
    end else begin
      presc <= tick ? '0 : presc + PRESC_W'(1);
      if (tick)
        phase <= phase + 4'd1;
      if (slot_start)
        digit <= frame_boundary ? '0 : digit + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/segment_scan_nd.sv
// Multiplexed 7-segment driver: shadowed hex/dp, leading-zero blanking, 16-step PWM, req/ack at frame edges.
// Outputs registered, 1 cycle after the causing tick; upd_req is held by the source until upd_ack.
module segment_scan_nd
  import segment_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 2048
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] disp_val,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic [7:0]              seg_out
);

  localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    tick;
  logic                    slot_start;
  logic                    frame_boundary;
  logic [DIGIT_W-1:0]      digit;
  logic [3:0]              phase;

  logic [4*NUM_DIGITS-1:0] sh_val, val_n;
  logic [NUM_DIGITS-1:0]   sh_dp, dp_n;
  logic [3:0]              bright_q, bright_n;
  logic [3:0]              phase_n;
  logic [DIGIT_W-1:0]      digit_n;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic                    load;
  logic                    show;
  logic [7:0]              glyph;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic [7:0]              out_n;

  segment_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .TICK_DIV   (TICK_DIV)
  ) u_timer (
    .sys_clk        (sys_clk),
    .reset_n        (reset_n),
    .tick           (tick),
    .slot_start     (slot_start),
    .frame_boundary (frame_boundary),
    .digit          (digit),
    .phase          (phase)
  );

  assign load = frame_boundary && upd_req;

  // Everything below describes the state as it will be after this edge,
  // so the registered pins move exactly one cycle after the tick.
  always_comb begin
    val_n    = load ? disp_val : sh_val;
    dp_n     = load ? dp_in : sh_dp;
    bright_n = slot_start ? brightness : bright_q;
    phase_n  = phase + {3'b000, tick};
    digit_n  = digit;
    if (slot_start)
      digit_n = frame_boundary ? '0 : digit + DIGIT_W'(1);

    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (val_n[4*i +: 4] == 4'h0) && !dp_n[i];
      lz_mask[i] = zero_run && lz_blank && (i != 0);
    end

    glyph    = hex_to_seg(val_n[4*int'(digit_n) +: 4]);
    glyph[7] = glyph[7] & ~dp_n[digit_n];
    show     = (phase_n < bright_n) && !lz_mask[digit_n];
    sel_n    = show ? ~(NUM_DIGITS'(1) << digit_n) : '1;
    out_n    = show ? glyph : SEG_BLANK;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_val      <= '0;
      sh_dp       <= '0;
      bright_q    <= '0;
      seg_sel     <= '1;
      seg_out     <= SEG_BLANK;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sh_val      <= val_n;
      sh_dp       <= dp_n;
      bright_q    <= bright_n;
      seg_sel     <= sel_n;
      seg_out     <= out_n;
      upd_ack     <= load;
      frame_start <= frame_boundary;
    end
  end

endmodule

// File: tb/tb_segment_scan_nd.sv
// Bench for segment_scan_nd (4 digits, TICK_DIV=4): cycle-count reference model feeds a scoreboard,
// plus directed slot checks for blanking, handshake, brightness and reset.
module tb_segment_scan_nd;

  localparam int ND = 4;
  localparam int TD = 4;

  logic          sys_clk;
  logic          reset_n;
  logic [4*ND-1:0] disp_val;
  logic [ND-1:0] dp_in;
  logic          lz_blank;
  logic [3:0]    brightness;
  logic          upd_req;
  logic          upd_ack;
  logic          frame_start;
  logic [ND-1:0] seg_sel;
  logic [7:0]    seg_out;

  segment_scan_nd #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .disp_val    (disp_val),
    .dp_in       (dp_in),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .frame_start (frame_start),
    .seg_sel     (seg_sel),
    .seg_out     (seg_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [ND-1:0] sel;
    logic [7:0]    out;
    logic          ack;
    logic          fs;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] glyph_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Reference model: position in the scan is derived from edges since reset release.
  int            m_n;
  logic [4*ND-1:0] m_val;
  logic [ND-1:0] m_dp;
  logic [3:0]    m_bri;

  always @(posedge sys_clk or negedge reset_n) begin
    int   k, ph, dg;
    logic ss, fb, blank;
    logic [3:0] nib;
    exp_t e;
    if (!reset_n) begin
      m_n   = 0;
      m_val = '0;
      m_dp  = '0;
      m_bri = '0;
      sb_q.delete();
    end else begin
      m_n++;
      k  = m_n / TD;
      ph = k % 16;
      dg = (k / 16) % ND;
      ss = (m_n % TD == 0) && (ph == 0);
      fb = ss && (dg == 0);
      e.fs  = fb;
      e.ack = fb && upd_req;
      if (e.ack) begin
        m_val = disp_val;
        m_dp  = dp_in;
      end
      if (ss) m_bri = brightness;
      blank = 1'b0;
      if (lz_blank && dg != 0) begin
        blank = 1'b1;
        for (int j = dg; j < ND; j++)
          if (m_val[4*j +: 4] != 4'h0 || m_dp[j]) blank = 1'b0;
      end
      nib = m_val[4*dg +: 4];
      if (ph < int'(m_bri) && !blank) begin
        e.sel     = '1;
        e.sel[dg] = 1'b0;
        e.out     = glyph_tab[nib];
        if (m_dp[dg]) e.out[7] = 1'b0;
      end else begin
        e.sel = '1;
        e.out = 8'hFF;
      end
      sb_q.push_back(e);
    end
  end

  always @(negedge sys_clk) begin
    exp_t e;
    if (reset_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_sel", 32'(seg_sel), 32'(e.sel));
      chk("sb_out", 32'(seg_out), 32'(e.out));
      chk("sb_ack", 32'(upd_ack), 32'(e.ack));
      chk("sb_fs",  32'(frame_start), 32'(e.fs));
    end
  end

  task automatic wait_ack();
    int i = 0;
    while (upd_ack !== 1'b1 && i < 700) begin
      @(negedge sys_clk);
      i++;
    end
    chk("ack_seen", 32'(upd_ack), 32'd1);
    chk("ack_with_fs", 32'(frame_start), 32'd1);
  endtask

  task automatic wait_fs();
    int i = 0;
    while (frame_start !== 1'b1 && i < 700) begin
      @(negedge sys_clk);
      i++;
    end
    chk("fs_seen", 32'(frame_start), 32'd1);
  endtask

  // Checks the current sample (phase 0 of a slot), then counts lit samples across the slot.
  task automatic look_slot(input string tag, input logic [ND-1:0] sel, input logic [7:0] out,
                           input int on_exp);
    int on = 0;
    chk({tag, "_sel"}, 32'(seg_sel), 32'(sel));
    chk({tag, "_out"}, 32'(seg_out), 32'(out));
    for (int i = 0; i < 64; i++) begin
      if (seg_sel !== 4'hF) on++;
      @(negedge sys_clk);
    end
    chk({tag, "_on"}, 32'(on), 32'(on_exp));
  endtask

  task automatic count_on(input string tag, input int cycles, input int on_exp);
    int on = 0;
    for (int i = 0; i < cycles; i++) begin
      if (seg_sel !== 4'hF) on++;
      @(negedge sys_clk);
    end
    chk(tag, 32'(on), 32'(on_exp));
  endtask

  initial begin
    int on, acks;
    reset_n    = 1'b0;
    disp_val   = '0;
    dp_in      = '0;
    lz_blank   = 1'b0;
    brightness = 4'd15;
    upd_req    = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_sel", 32'(seg_sel), 32'hF);
    chk("rst_out", 32'(seg_out), 32'hFF);
    chk("rst_ack", 32'(upd_ack), 32'd0);
    chk("rst_fs",  32'(frame_start), 32'd0);

    // Slot 0 after reset runs with latched brightness 0; slot 1 shows shadow 0.
    reset_n = 1'b1;
    count_on("boot_dark", 64, 0);
    chk("boot_d1_sel", 32'(seg_sel), 32'hD);
    chk("boot_d1_out", 32'(seg_out), 32'hC0);

    disp_val = 16'h1234;
    upd_req  = 1'b1;
    wait_ack();
    upd_req = 1'b0;
    look_slot("s1234_d0", 4'b1110, 8'h99, 60);
    look_slot("s1234_d1", 4'b1101, 8'hB0, 60);
    look_slot("s1234_d2", 4'b1011, 8'hA4, 60);
    look_slot("s1234_d3", 4'b0111, 8'hF9, 60);

    // Mid-frame request: the scoreboard holds the old glyphs until the boundary.
    repeat (100) @(negedge sys_clk);
    disp_val = 16'hABCD;
    upd_req  = 1'b1;
    wait_ack();
    chk("hs_new_sel", 32'(seg_sel), 32'hE);
    chk("hs_new_out", 32'(seg_out), 32'hA1);
    upd_req = 1'b0;
    @(negedge sys_clk);
    chk("hs_ack_1cyc", 32'(upd_ack), 32'd0);

    lz_blank = 1'b1;
    disp_val = 16'h0050;
    upd_req  = 1'b1;
    wait_ack();
    upd_req = 1'b0;
    look_slot("lz_d0", 4'b1110, 8'hC0, 60);
    look_slot("lz_d1", 4'b1101, 8'h92, 60);
    look_slot("lz_d2", 4'b1111, 8'hFF, 0);
    look_slot("lz_d3", 4'b1111, 8'hFF, 0);

    dp_in   = 4'b1000;
    upd_req = 1'b1;
    wait_ack();
    upd_req = 1'b0;
    look_slot("lzdp_d0", 4'b1110, 8'hC0, 60);
    look_slot("lzdp_d1", 4'b1101, 8'h92, 60);
    look_slot("lzdp_d2", 4'b1011, 8'hC0, 60);
    look_slot("lzdp_d3", 4'b0111, 8'h40, 60);

    brightness = 4'd0;
    repeat (64) @(negedge sys_clk);
    count_on("bri0_frame", 256, 0);
    brightness = 4'd15;
    repeat (64) @(negedge sys_clk);
    on = 0;
    for (int i = 0; i < 64; i++) begin
      if (seg_sel !== 4'hF) on++;
      if (i == 20) brightness = 4'd8;
      @(negedge sys_clk);
    end
    chk("bri_keep15", 32'(on), 32'd60);
    count_on("bri_next8", 64, 32);

    // Asynchronous reset while digit 2 is lit.
    brightness = 4'd15;
    lz_blank   = 1'b0;
    wait_fs();
    repeat (138) @(negedge sys_clk);
    chk("pre_rst_sel", 32'(seg_sel), 32'hB);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_sel", 32'(seg_sel), 32'hF);
    chk("arst_out", 32'(seg_out), 32'hFF);
    chk("arst_ack", 32'(upd_ack), 32'd0);
    chk("arst_fs",  32'(frame_start), 32'd0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    count_on("rerun_dark", 64, 0);
    chk("rerun_d1_sel", 32'(seg_sel), 32'hD);
    chk("rerun_d1_out", 32'(seg_out), 32'hC0);
    acks = 0;
    for (int i = 0; i < 192; i++) begin
      if (upd_ack === 1'b1) acks++;
      @(negedge sys_clk);
    end
    chk("rerun_no_ack", 32'(acks), 32'd0);
    chk("rerun_fs", 32'(frame_start), 32'd1);
    chk("rerun_d0_sel", 32'(seg_sel), 32'hE);
    chk("rerun_d0_out", 32'(seg_out), 32'hC0);

    repeat (4) @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
